// File: rtl/sap_ctrl_pkg.sv
// sap_ctrl_pkg: shared types and defaults for the SAP-1.5 control unit.
package sap_ctrl_pkg;
  typedef enum logic [1:0] {RUN, WAIT, STEP, HALT} seq_state_t;
  localparam int DEFAULT_NUM_TSTATES = 6;
  localparam int DEFAULT_FETCH_STEPS = 2;
endpackage

// File: rtl/edge_detect_rise.sv
// edge_detect_rise: rising-edge detector comparing a level against its registered copy.
module edge_detect_rise (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);
  logic prev;
  always_ff @(posedge clk or negedge reset)
    if (!reset) prev <= 1'b0;
    else prev <= d;
  assign rise = d & ~prev;
endmodule

// File: rtl/microstep_sequencer.sv
// microstep_sequencer: T-state sequencer with run/single-step modes, early end and latched halt.
module microstep_sequencer
  import sap_ctrl_pkg::*;
#(
  parameter int NUM_TSTATES = DEFAULT_NUM_TSTATES,
  parameter int FETCH_STEPS = DEFAULT_FETCH_STEPS,
  localparam int STEP_W = $clog2(NUM_TSTATES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run_mode,
  input  logic                   step_req,
  input  logic                   end_instr,
  input  logic                   halt_req,
  input  logic                   resume,
  output logic [STEP_W-1:0]      tstate,
  output logic [NUM_TSTATES-1:0] tstate_onehot,
  output logic                   step_en,
  output logic                   fetch_phase,
  output logic                   halted,
  output logic                   instr_done
);
  if (NUM_TSTATES < 3 || NUM_TSTATES > 16) begin : g_bad_num
    $error("NUM_TSTATES must be in 3..16");
  end
  if (FETCH_STEPS >= NUM_TSTATES) begin : g_bad_fetch
    $error("FETCH_STEPS must be below NUM_TSTATES");
  end
  seq_state_t state, state_next, cur;
  logic fresh, rise, wrap;
  logic [STEP_W-1:0] tstate_next;
  edge_detect_rise u_edge (
    .clk  (clk),
    .reset(reset),
    .d    (step_req),
    .rise (rise)
  );
  // The first cycle after reset picks RUN or WAIT from the live run_mode input.
  assign cur = fresh ? (run_mode ? RUN : WAIT) : state;
  always_comb begin
    step_en = reset && (cur == RUN || cur == STEP);
    wrap = (end_instr && !fetch_phase) || tstate == STEP_W'(NUM_TSTATES - 1);
    instr_done = step_en && (halt_req || wrap);
    tstate_next = step_en ? ((halt_req || wrap) ? '0 : tstate + 1'b1) : tstate;
    state_next = cur;
    case (cur)
      RUN:     state_next = halt_req ? HALT : run_mode ? RUN : WAIT;
      WAIT:    state_next = rise ? STEP : WAIT;
      STEP:    state_next = halt_req ? HALT : run_mode ? RUN : WAIT;
      HALT:    state_next = (resume && !halt_req) ? (run_mode ? RUN : WAIT) : HALT;
      default: state_next = WAIT;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= WAIT;
      fresh <= 1'b1;
      tstate <= '0;
      tstate_onehot <= NUM_TSTATES'(1);
      fetch_phase <= FETCH_STEPS > 0;
      halted <= 1'b0;
    end else begin
      state <= state_next;
      fresh <= 1'b0;
      tstate <= tstate_next;
      tstate_onehot <= NUM_TSTATES'(1) << tstate_next;
      fetch_phase <= tstate_next < STEP_W'(FETCH_STEPS);
      halted <= state_next == HALT;
    end
endmodule

// File: tb/tb_microstep_sequencer.sv
// tb_microstep_sequencer: table vectors, directed corner sequences and a randomized model check.
module tb_microstep_sequencer;
  localparam int N = 6;
  localparam int F = 2;
  logic clk = 0, reset = 0;
  logic run_mode = 0, step_req = 0, end_instr = 0, halt_req = 0, resume = 0;
  logic [2:0] tstate;
  logic [5:0] tstate_onehot;
  logic step_en, fetch_phase, halted, instr_done;
  logic [2:0] t2;
  logic [7:0] oh2;
  logic en2, fe2, h2, d2;
  int vectors = 0, miscompares = 0, en_count = 0;
  int m_t;
  bit m_halted, m_running, m_granted, m_fresh, m_seen;
  typedef struct {
    bit rm, sr, ei, hr, rs;
    int t;
    bit en, d, h;
  } vec_t;
  vec_t tbl[$];
  always #5 clk = ~clk;
  microstep_sequencer dut (
    .clk(clk), .reset(reset), .run_mode(run_mode), .step_req(step_req),
    .end_instr(end_instr), .halt_req(halt_req), .resume(resume),
    .tstate(tstate), .tstate_onehot(tstate_onehot), .step_en(step_en),
    .fetch_phase(fetch_phase), .halted(halted), .instr_done(instr_done)
  );
  microstep_sequencer #(.NUM_TSTATES(8), .FETCH_STEPS(3)) dut8 (
    .clk(clk), .reset(reset), .run_mode(1'b1), .step_req(1'b0),
    .end_instr(1'b0), .halt_req(1'b0), .resume(1'b0),
    .tstate(t2), .tstate_onehot(oh2), .step_en(en2),
    .fetch_phase(fe2), .halted(h2), .instr_done(d2)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic vec_t row(bit rm, sr, ei, hr, rs, int t, bit en, d, h);
    vec_t v;
    v.rm = rm; v.sr = sr; v.ei = ei; v.hr = hr; v.rs = rs;
    v.t = t; v.en = en; v.d = d; v.h = h;
    return v;
  endfunction
  task automatic do_reset(input bit rm);
    @(negedge clk);
    reset = 0; run_mode = rm;
    step_req = 0; end_instr = 0; halt_req = 0; resume = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    m_t = 0; m_halted = 0; m_running = 0; m_granted = 0; m_fresh = 1; m_seen = 0;
  endtask
  // Model: an instruction step commits when not halted and either free-running or granted a step.
  task automatic tick(input bit rm, sr, ei, hr, rs);
    bit r, commit, done;
    run_mode = rm; step_req = sr; end_instr = ei; halt_req = hr; resume = rs;
    r = m_fresh ? rm : m_running;
    commit = !m_halted && (r || m_granted);
    done = commit && (hr || (ei && m_t >= F) || m_t == N - 1);
    #1;
    check("tstate", 32'(tstate), m_t);
    check("onehot", 32'(tstate_onehot), 1 << m_t);
    check("fetch_phase", 32'(fetch_phase), 32'(m_t < F));
    check("step_en", 32'(step_en), 32'(commit));
    check("instr_done", 32'(instr_done), 32'(done));
    check("halted", 32'(halted), 32'(m_halted));
    if (step_en) en_count++;
    @(posedge clk);
    if (commit) m_t = done ? 0 : m_t + 1;
    if (m_halted) begin
      if (rs && !hr) begin m_halted = 0; m_running = rm; end
    end else if (commit && hr) begin
      m_halted = 1; m_running = 0; m_granted = 0;
    end else if (r) m_running = rm;
    else if (m_granted) begin m_granted = 0; m_running = rm; end
    else m_granted = sr && !m_seen;
    m_seen = sr;
    m_fresh = 0;
    @(negedge clk);
  endtask
  initial begin
    tbl.push_back(row(1,0,1,0,0, 0,1,0,0));
    tbl.push_back(row(1,0,1,0,0, 1,1,0,0));
    tbl.push_back(row(1,0,0,0,0, 2,1,0,0));
    tbl.push_back(row(1,0,1,0,0, 3,1,1,0));
    tbl.push_back(row(1,0,0,0,0, 0,1,0,0));
    tbl.push_back(row(1,0,0,0,0, 1,1,0,0));
    tbl.push_back(row(1,0,0,0,0, 2,1,0,0));
    tbl.push_back(row(1,0,0,0,0, 3,1,0,0));
    tbl.push_back(row(1,0,0,0,0, 4,1,0,0));
    tbl.push_back(row(1,0,0,0,0, 5,1,1,0));
    tbl.push_back(row(1,0,0,0,0, 0,1,0,0));
    tbl.push_back(row(1,0,0,0,0, 1,1,0,0));
    tbl.push_back(row(1,0,0,1,1, 2,1,1,0));
    tbl.push_back(row(1,0,0,1,1, 0,0,0,1));
    tbl.push_back(row(1,0,0,0,1, 0,0,0,1));
    tbl.push_back(row(1,0,0,0,0, 0,1,0,0));
    tbl.push_back(row(1,0,0,0,0, 1,1,0,0));
    tbl.push_back(row(0,0,0,0,0, 2,1,0,0));
    tbl.push_back(row(0,0,0,0,0, 3,0,0,0));
    // Table vectors in free-run mode from reset.
    do_reset(1);
    for (int i = 0; i < tbl.size(); i++) begin
      run_mode = tbl[i].rm; step_req = tbl[i].sr; end_instr = tbl[i].ei;
      halt_req = tbl[i].hr; resume = tbl[i].rs;
      #1;
      check($sformatf("tbl%0d_tstate", i), 32'(tstate), tbl[i].t);
      check($sformatf("tbl%0d_step_en", i), 32'(step_en), 32'(tbl[i].en));
      check($sformatf("tbl%0d_instr_done", i), 32'(instr_done), 32'(tbl[i].d));
      check($sformatf("tbl%0d_halted", i), 32'(halted), 32'(tbl[i].h));
      @(negedge clk);
    end
    // Asynchronous reset mid-instruction at tstate 3.
    do_reset(1);
    repeat (3) tick(1, 0, 0, 0, 0);
    check("pre_reset_tstate", 32'(tstate), 3);
    #2 reset = 0;
    #1;
    check("async_tstate", 32'(tstate), 0);
    check("async_step_en", 32'(step_en), 0);
    check("async_halted", 32'(halted), 0);
    @(negedge clk);
    reset = 1;
    m_t = 0; m_halted = 0; m_running = 0; m_granted = 0; m_fresh = 1; m_seen = 0;
    repeat (8) tick(1, 0, 0, 0, 0);
    // Single-step: three pulses 10 cycles apart, then a held level.
    do_reset(0);
    en_count = 0;
    for (int p = 0; p < 3; p++) begin
      tick(0, 1, 0, 0, 0);
      repeat (9) tick(0, 0, 0, 0, 0);
    end
    check("ss_en_count", en_count, 3);
    check("ss_tstate", 32'(tstate), 3);
    en_count = 0;
    repeat (10) tick(0, 1, 0, 0, 0);
    repeat (3) tick(0, 0, 0, 0, 0);
    check("held_en_count", en_count, 1);
    check("held_tstate", 32'(tstate), 4);
    // Halt at tstate 2, hold 20 cycles, then resume.
    do_reset(1);
    repeat (2) tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 1, 0);
    en_count = 0;
    repeat (20) tick(1, 0, 0, 0, 0);
    check("halt_en_count", en_count, 0);
    check("halt_flag", 32'(halted), 1);
    tick(1, 0, 0, 1, 1);
    tick(1, 0, 0, 0, 1);
    repeat (4) tick(1, 0, 0, 0, 0);
    check("resumed_tstate", 32'(tstate), 4);
    // Eight-step build: wrap at 7, three fetch steps.
    do_reset(1);
    for (int i = 0; i < 12; i++) begin
      #1;
      check("n8_tstate", 32'(t2), i % 8);
      check("n8_fetch", 32'(fe2), 32'((i % 8) < 3));
      check("n8_onehot", 32'(oh2), 1 << (i % 8));
      check("n8_done", 32'(d2), 32'((i % 8) == 7));
      if (i == 7) check("n8_onehot_top", 32'(oh2), 32'h80);
      @(negedge clk);
    end
    // Randomized stimulus against the model.
    do_reset(1);
    begin
      bit rm = 1, sr = 0;
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(0, 19) == 0) rm = ~rm;
        if ($urandom_range(0, 3) == 0) sr = ~sr;
        tick(rm, sr, $urandom_range(0, 9) < 3, $urandom_range(0, 39) == 0,
             $urandom_range(0, 9) == 0);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
